// File: rtl/divn_pkg.sv
// Shared definitions for the divisible-by-N scheduler slice.
//   state_t  : scheduler FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   width_of : bit width needed to hold values 0..value-1, never less than 1,
//              used for the id, residue and bit-count widths.
package divn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int width_of(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/mod_n_residue_step.sv
// One step of a serial mod-MOD residue engine plus its residue register.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clr          clear the residue to 0 (start of a new word)
//   en           advance the residue by one input bit
//   bit_in       next word bit, MSB first
//   residue_next f(residue, bit_in), the residue after consuming bit_in
module mod_n_residue_step #(
    parameter int MOD = 5,
    parameter int RW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [RW-1:0] residue_next
);

    localparam logic [RW:0] MOD_W = (RW+1)'(MOD);

    logic [RW-1:0] residue;
    logic [RW:0]   t;

    // residue < MOD always holds, so t = 2*residue + b < 2*MOD and a single
    // conditional subtract brings it back into range.
    always_comb begin
        t            = {residue, bit_in};
        residue_next = t[RW-1:0];
        if (t >= MOD_W) begin
            residue_next = RW'(t - MOD_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            residue <= '0;
        end else if (en) begin
            residue <= residue_next;
        end
    end

endmodule

// File: rtl/divisible_n_scheduler.sv
// Round-robin scheduler sharing one serial mod-MOD residue engine among
// N_REQ requesters. A granted word is shifted MSB-first through the engine,
// one bit per cycle, and the residue plus a divisible flag are returned
// tagged with the requester id.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester word valid
//   req_data     word of requester i at [i*WIDTH +: WIDTH]
//   req_ready    one-hot accept, only ever set in IDLE
//   rsp_valid    result valid (registered)
//   rsp_ready    result accepted
//   rsp_id       requester id of the result
//   rsp_residue  word mod MOD
//   rsp_div      1 iff rsp_residue == 0
//   busy         1 while a word is shifting or a result is pending
module divisible_n_scheduler
    import divn_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 16,
    parameter  int MOD   = 5,
    localparam int IDW   = width_of(N_REQ),
    localparam int RW    = width_of(MOD),
    localparam int CW    = width_of(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [RW-1:0]          rsp_residue,
    output logic                   rsp_div,
    output logic                   busy
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;

    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic [RW-1:0]    residue_next;
    logic             last_bit;
    logic             start_job;

    // Rotate-priority search: the winner is the valid requester with the
    // smallest distance from rr_ptr going upward modulo N_REQ.
    always_comb begin
        int best_d;
        int d;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_word = '0;
        best_d     = N_REQ;
        d          = 0;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i + N_REQ - int'(rr_ptr)) % N_REQ;
            if (req_valid[i] && (d < best_d)) begin
                best_d     = d;
                grant_any  = 1'b1;
                grant_idx  = IDW'(i);
                grant_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign start_job = (state == IDLE) && grant_any;
    assign req_ready = start_job ? (N_REQ'(1) << grant_idx) : '0;
    assign last_bit  = (count == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);

    mod_n_residue_step #(
        .MOD (MOD),
        .RW  (RW)
    ) u_step (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_job),
        .en           (state == SHIFT),
        .bit_in       (shreg[WIDTH-1]),
        .residue_next (residue_next)
    );

    // Scheduler FSM. The response registers are loaded from the engine's
    // next-residue value on the final SHIFT cycle, so the result is visible
    // the moment the FSM enters DONE and stays frozen until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            shreg       <= '0;
            count       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_residue <= '0;
            rsp_div     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        shreg  <= grant_word;
                        cur_id <= grant_idx;
                        count  <= '0;
                        rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    count <= count + 1'b1;
                    if (last_bit) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_residue <= residue_next;
                        rsp_div     <= (residue_next == '0);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisible_n_scheduler.sv
// Self-checking bench for divisible_n_scheduler. Two instances, with
// divisors 5 and 7, see identical stimulus; a transaction-level model
// predicts grants, timing and residues (word % divisor) and checks both
// every cycle.
module tb_divisible_n_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic                   rsp_ready;

    logic [N_REQ-1:0] req_ready5, req_ready7;
    logic             rsp_valid5, rsp_valid7;
    logic [1:0]       rsp_id5, rsp_id7;
    logic [2:0]       rsp_residue5, rsp_residue7;
    logic             rsp_div5, rsp_div7;
    logic             busy5, busy7;

    divisible_n_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MOD(5)) dut5 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready5), .rsp_valid(rsp_valid5), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id5), .rsp_residue(rsp_residue5), .rsp_div(rsp_div5),
        .busy(busy5)
    );

    divisible_n_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MOD(7)) dut7 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready7), .rsp_valid(rsp_valid7), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id7), .rsp_residue(rsp_residue7), .rsp_div(rsp_div7),
        .busy(busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side state driven by the scenarios
    logic [N_REQ-1:0]       tb_valid;
    logic [N_REQ*WIDTH-1:0] tb_data;
    logic                   tb_rsp_ready;
    bit                     auto_drop;

    // Model state: phase 0 idle, 1 shifting, 2 result pending
    int               m_phase;
    int               m_ptr;
    int               m_count;
    int               job_id;
    logic [WIDTH-1:0] job_word;
    int               resp_count;
    int               cycle_no;
    int               grant_cycle;
    int               rsp_cycle;
    int               obs_grants[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cycle_no);
        end
    endtask

    // Predict and check one cycle, then advance the model to what the coming
    // clock edge should produce.
    task automatic modelCycle();
        int g;
        int idx;
        logic [N_REQ-1:0]       exp_ready;
        logic [N_REQ-1:0]       vshift;
        logic [N_REQ*WIDTH-1:0] dshift;
        g = -1;
        exp_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            vshift = req_ready5 >> i;
            if (vshift[0]) obs_grants.push_back(i);
        end
        checkOutput("busy5", int'(busy5), int'(m_phase != 0));
        checkOutput("busy7", int'(busy7), int'(m_phase != 0));
        case (m_phase)
            0: begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (m_ptr + k) % N_REQ;
                    vshift = req_valid >> idx;
                    if (g < 0 && vshift[0]) g = idx;
                end
                if (g >= 0) exp_ready = N_REQ'(1) << g;
                checkOutput("req_ready5", int'(req_ready5), int'(exp_ready));
                checkOutput("req_ready7", int'(req_ready7), int'(exp_ready));
                checkOutput("rsp_valid_idle", int'(rsp_valid5), 0);
                if (g >= 0) begin
                    dshift      = req_data >> (g * WIDTH);
                    job_word    = dshift[WIDTH-1:0];
                    job_id      = g;
                    m_ptr       = (g + 1) % N_REQ;
                    m_phase     = 1;
                    m_count     = 0;
                    grant_cycle = cycle_no;
                    if (auto_drop) tb_valid = tb_valid & ~(N_REQ'(1) << g);
                end
            end
            1: begin
                checkOutput("req_ready_shift", int'(req_ready5 | req_ready7), 0);
                checkOutput("rsp_valid_shift", int'(rsp_valid5 | rsp_valid7), 0);
                m_count++;
                if (m_count == WIDTH) m_phase = 2;
            end
            default: begin
                if (rsp_cycle < grant_cycle) rsp_cycle = cycle_no;
                checkOutput("rsp_valid5", int'(rsp_valid5), 1);
                checkOutput("rsp_valid7", int'(rsp_valid7), 1);
                checkOutput("req_ready_done", int'(req_ready5 | req_ready7), 0);
                checkOutput("rsp_id5", int'(rsp_id5), job_id);
                checkOutput("rsp_id7", int'(rsp_id7), job_id);
                checkOutput("rsp_residue5", int'(rsp_residue5), int'(job_word % 5));
                checkOutput("rsp_div5", int'(rsp_div5), int'(job_word % 5 == 0));
                checkOutput("rsp_residue7", int'(rsp_residue7), int'(job_word % 7));
                checkOutput("rsp_div7", int'(rsp_div7), int'(job_word % 7 == 0));
                if (rsp_ready) begin
                    m_phase = 0;
                    resp_count++;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs (called at posedge+1), check it, and return
    // at the following posedge+1.
    task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [N_REQ*WIDTH-1:0] d,
                                 input logic rr, input logic r);
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        rst       = r;
        #1;
        if (!r) modelCycle();
        @(posedge clk);
        #1;
        cycle_no++;
        if (r) begin
            m_phase = 0;
            m_ptr   = 0;
        end
    endtask

    task automatic stepTb();
        applyStimulus(tb_valid, tb_data, tb_rsp_ready, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid5 | rsp_valid7), 0);
        checkOutput({tag, "_rsp_id"}, int'(rsp_id5 | rsp_id7), 0);
        checkOutput({tag, "_rsp_residue"}, int'(rsp_residue5 | rsp_residue7), 0);
        checkOutput({tag, "_rsp_div"}, int'(rsp_div5 | rsp_div7), 0);
        checkOutput({tag, "_busy"}, int'(busy5 | busy7), 0);
        checkOutput({tag, "_req_ready"}, int'(req_ready5 | req_ready7), 0);
    endtask

    task automatic doReset();
        tb_valid = '0;
        applyStimulus('0, tb_data, 1'b0, 1'b1);
        applyStimulus('0, tb_data, 1'b0, 1'b1);
        req_valid = '0;
        #1;
        checkAllZero("reset");
    endtask

    task automatic waitResponses(input int target, input string tag);
        int k;
        k = 0;
        while (resp_count < target && k < 400) begin
            stepTb();
            k++;
        end
        if (resp_count < target) checkOutput({tag, "_timeout"}, resp_count, target);
    endtask

    task automatic waitPhase(input int phase, input int cnt, input string tag);
        int k;
        k = 0;
        while (!(m_phase == phase && (phase != 1 || m_count == cnt)) && k < 400) begin
            stepTb();
            k++;
        end
        if (k >= 400) checkOutput({tag, "_timeout"}, m_phase, phase);
    endtask

    task automatic setWord(input int i, input logic [WIDTH-1:0] w);
        tb_data[i*WIDTH +: WIDTH] = w;
    endtask

    initial begin
        int exp_order[5];
        logic [WIDTH-1:0] w;
        exp_order = '{0, 1, 2, 3, 0};
        m_phase = 0; m_ptr = 0; m_count = 0; job_id = 0; job_word = '0;
        resp_count = 0; cycle_no = 0; grant_cycle = 0; rsp_cycle = -1;
        tb_valid = '0; tb_data = '0; tb_rsp_ready = 1'b1; auto_drop = 1'b1;
        req_valid = '0; req_data = '0; rsp_ready = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        doReset();

        // 1: req0 sends 35, latency grant+WIDTH+1
        $display("[TB] test 1: req0 word 35");
        setWord(0, 16'd35);
        tb_valid = 4'b0001;
        rsp_cycle = -1;
        waitResponses(resp_count + 1, "t1");
        checkOutput("t1_latency", rsp_cycle - grant_cycle, WIDTH + 1);
        stepTb();

        // 2: req2 sends 37
        $display("[TB] test 2: req2 word 37");
        setWord(2, 16'd37);
        tb_valid = 4'b0100;
        waitResponses(resp_count + 1, "t2");
        stepTb();

        // 3: req1 sends 0xFFFF (65535 % 7 == 1)
        $display("[TB] test 3: req1 word 0xFFFF");
        setWord(1, 16'hFFFF);
        tb_valid = 4'b0010;
        waitResponses(resp_count + 1, "t3");
        stepTb();

        // 4: all four held valid from reset -> grants 0,1,2,3,0
        $display("[TB] test 4: all requesters held valid");
        doReset();
        for (int i = 0; i < N_REQ; i++) setWord(i, WIDTH'($urandom));
        tb_valid = '1;
        auto_drop = 1'b0;
        obs_grants.delete();
        waitResponses(resp_count + 5, "t4");
        tb_valid = '0;
        auto_drop = 1'b1;
        stepTb();
        checkOutput("t4_grant_count", obs_grants.size(), 5);
        for (int i = 0; i < 5 && i < obs_grants.size(); i++) begin
            checkOutput("t4_grant_order", obs_grants[i], exp_order[i]);
        end

        // 5: backpressure in DONE for 6 cycles, req1 waiting
        $display("[TB] test 5: response backpressure");
        setWord(0, 16'd1234);
        tb_valid = 4'b0001;
        tb_rsp_ready = 1'b0;
        waitPhase(2, 0, "t5");
        setWord(1, 16'd777);
        tb_valid = 4'b0010;
        for (int i = 0; i < 6; i++) stepTb();
        checkOutput("t5_still_pending", m_phase, 2);
        tb_rsp_ready = 1'b1;
        stepTb();
        stepTb();
        checkOutput("t5_next_grant_id", job_id, 1);
        waitResponses(resp_count + 1, "t5b");
        stepTb();

        // 6: reset at count=8 mid-SHIFT, then req3 sends 10
        $display("[TB] test 6: reset mid-shift");
        setWord(0, 16'hBEEF);
        tb_valid = 4'b0001;
        waitPhase(1, 8, "t6");
        applyStimulus(tb_valid, tb_data, tb_rsp_ready, 1'b1);
        req_valid = '0;
        #1;
        checkAllZero("t6_reset");
        for (int i = 0; i < 20; i++) stepTb();
        setWord(3, 16'd10);
        tb_valid = 4'b1000;
        waitResponses(resp_count + 1, "t6b");
        stepTb();

        // Randomized traffic with random backpressure and forfeited requests
        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!tb_valid[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 7))
                        0:       w = '0;
                        1:       w = '1;
                        default: w = WIDTH'($urandom);
                    endcase
                    setWord(i, w);
                    tb_valid[i] = 1'b1;
                end else if (tb_valid[i] && $urandom_range(0, 31) == 0) begin
                    tb_valid[i] = 1'b0;
                end
            end
            tb_rsp_ready = ($urandom_range(0, 3) != 0);
            stepTb();
        end
        tb_valid = '0;
        tb_rsp_ready = 1'b1;
        waitPhase(0, 0, "drain");
        stepTb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
